// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state encoding and DMType codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_DM = 2'd1,
        GNT_IF = 2'd2
    } arb_state_t;

    // Same encoding as the pipeline's ctrl_encode_def; fetches always use DM_WORD.
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus between the arbiter (master) and the memory (slave).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [2:0]    mem_type;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and load; used for the optional wait-cycle counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between fetch and load/store, data side wins ties.
// Optional wait-cycle counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [2:0]    dm_type,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          dm_stall,
    mem_port_arbiter_if.master mem
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_if_wait,
    output logic [31:0]   perf_dm_wait
`endif
);
    arb_state_t state;
    logic       kill_pend;
    logic       free;
    logic       dm_want;
    logic       if_want;

    // The side just acked drops out of this cycle's arbitration, so both-busy traffic alternates.
    assign free    = (state == IDLE) || mem.mem_ack;
    assign dm_want = dm_req && (state != GNT_DM);
    assign if_want = if_req && (state != GNT_IF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_type  <= 3'b000;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            kill_pend     <= 1'b0;
        end else begin
            if (free) begin
                if (dm_want) begin
                    state         <= GNT_DM;
                    mem.mem_req   <= 1'b1;
                    mem.mem_we    <= dm_we;
                    mem.mem_type  <= dm_type;
                    mem.mem_addr  <= dm_addr;
                    mem.mem_wdata <= dm_wdata;
                end else if (if_want) begin
                    state         <= GNT_IF;
                    mem.mem_req   <= 1'b1;
                    mem.mem_we    <= 1'b0;
                    mem.mem_type  <= DM_WORD;
                    mem.mem_addr  <= if_addr;
                    mem.mem_wdata <= '0;
                end else begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                end
            end

            // A killed fetch still runs to its ack; the flag just hides that ack from IF.
            if (state == GNT_IF && mem.mem_ack)
                kill_pend <= 1'b0;
            else if (if_kill && (state == GNT_IF || (state == IDLE && !dm_want && if_want)))
                kill_pend <= 1'b1;
        end
    end

    assign if_ready = mem.mem_ack && (state == GNT_IF) && !kill_pend;
    assign dm_ready = mem.mem_ack && (state == GNT_DM);
    assign if_rdata = (state == GNT_IF) ? mem.mem_rdata : '0;
    assign dm_rdata = (state == GNT_DM) ? mem.mem_rdata : '0;
    assign if_stall = if_req && !if_ready;
    assign dm_stall = dm_req && !dm_ready;

`ifdef ARB_PERF_CNT_EN
    sat_counter #(.W(32)) u_if_wait (
        .clk(clk), .clr(reset), .inc(if_stall), .load(1'b0), .load_val(32'd0), .count(perf_if_wait)
    );
    sat_counter #(.W(32)) u_dm_wait (
        .clk(clk), .clr(reset), .inc(dm_stall), .load(1'b0), .load_val(32'd0), .count(perf_dm_wait)
    );
`endif
endmodule
